// File: rtl/perceptron_pkg.sv
// Shared state encoding, default sizing and helpers for the perceptron
// training controller and its index counter.
package perceptron_pkg;

    localparam int DEF_N_IN      = 4;
    localparam int DEF_MAX_EPOCH = 255;
    localparam int DEF_EPOCH_W   = 8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_EPOCH,
        S_FETCH,
        S_CLR,
        S_ACC,
        S_BIAS,
        S_CHECK,
        S_UPD,
        S_UPDB,
        S_ENDEP,
        S_FINISH
    } state_t;

    // Index width is never allowed to collapse to zero bits.
    function automatic int idx_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/perceptron_train_ctrl_n_if.sv
// Sample-memory handshake and datapath strobes between the training
// controller (master) and the sample memory / datapath (slave).
interface perceptron_train_ctrl_n_if
    import perceptron_pkg::*;
#(
    parameter int N_IN = DEF_N_IN
);
    localparam int IDX_W = idx_width(N_IN);

    logic             smp_valid;
    logic             smp_last;
    logic             smp_ready;
    logic             neq;
    logic             init_wb;
    logic             init_yin;
    logic             ld_smp;
    logic             acc_en;
    logic             add_b;
    logic             upd_w;
    logic             upd_b;
    logic [IDX_W-1:0] idx;

    modport master (
        input  smp_valid, smp_last, neq,
        output smp_ready, init_wb, init_yin, ld_smp, acc_en, add_b,
               upd_w, upd_b, idx
    );

    modport slave (
        output smp_valid, smp_last, neq,
        input  smp_ready, init_wb, init_yin, ld_smp, acc_en, add_b,
               upd_w, upd_b, idx
    );

endinterface

// File: rtl/perceptron_train_ctrl_n_idx_counter.sv
// Input-index counter for the accumulate and weight-update sweeps; wraps
// to zero after the terminal count N_IN-1.
module idx_counter
    import perceptron_pkg::*;
#(
    parameter int N_IN  = DEF_N_IN,
    parameter int IDX_W = idx_width(N_IN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [IDX_W-1:0] cnt,
    output logic             tc
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_IN - 1);
    localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

    assign tc = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + ONE;
        end
    end

endmodule

// File: rtl/perceptron_train_ctrl_n.sv
// Perceptron training sequencer: walks samples, sweeps accumulate and
// weight-update strobes, and tracks epochs until convergence or timeout.
module perceptron_train_ctrl_n
    import perceptron_pkg::*;
#(
    parameter int N_IN      = DEF_N_IN,
    parameter int MAX_EPOCH = DEF_MAX_EPOCH,
    parameter int EPOCH_W   = DEF_EPOCH_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    perceptron_train_ctrl_n_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic                  converged,
    output logic                  timeout,
    output logic [EPOCH_W-1:0]    epoch
);
    localparam int               IDX_W     = idx_width(N_IN);
    localparam logic [EPOCH_W:0] EPOCH_LIM = (EPOCH_W + 1)'(MAX_EPOCH);
    localparam logic [EPOCH_W:0] EPOCH_ONE = (EPOCH_W + 1)'(1);

    state_t           state;
    logic             err_flag;
    logic             last_flag;
    logic [IDX_W-1:0] cnt;
    logic             cnt_tc;
    logic             cnt_clr;
    logic             cnt_en;
    logic [EPOCH_W:0] epoch_inc;

    // One bit of headroom so the limit compare cannot alias on wrap.
    assign epoch_inc = {1'b0, epoch} + EPOCH_ONE;

    assign cnt_clr = (state == S_CLR) || (state == S_CHECK);
    assign cnt_en  = (state == S_ACC) || (state == S_UPD);

    idx_counter #(
        .N_IN  (N_IN),
        .IDX_W (IDX_W)
    ) u_idx (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .cnt (cnt),
        .tc  (cnt_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            err_flag  <= 1'b0;
            last_flag <= 1'b0;
            converged <= 1'b0;
            timeout   <= 1'b0;
            epoch     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        converged <= 1'b0;
                        timeout   <= 1'b0;
                        epoch     <= '0;
                        state     <= S_INIT;
                    end
                end
                S_INIT:  state <= S_EPOCH;
                S_EPOCH: begin
                    err_flag  <= 1'b0;
                    last_flag <= 1'b0;
                    state     <= S_FETCH;
                end
                S_FETCH: begin
                    if (bus.smp_valid) begin
                        last_flag <= bus.smp_last;
                        state     <= S_CLR;
                    end
                end
                S_CLR:   state <= S_ACC;
                S_ACC:   if (cnt_tc) state <= S_BIAS;
                S_BIAS:  state <= S_CHECK;
                S_CHECK: begin
                    if (bus.neq) begin
                        err_flag <= 1'b1;
                        state    <= S_UPD;
                    end else begin
                        state <= last_flag ? S_ENDEP : S_FETCH;
                    end
                end
                S_UPD:   if (cnt_tc) state <= S_UPDB;
                S_UPDB:  state <= last_flag ? S_ENDEP : S_FETCH;
                S_ENDEP: begin
                    epoch <= epoch_inc[EPOCH_W-1:0];
                    // A clean epoch wins over reaching the limit on the same pass.
                    if (!err_flag) begin
                        converged <= 1'b1;
                        state     <= S_FINISH;
                    end else if (epoch_inc == EPOCH_LIM) begin
                        timeout <= 1'b1;
                        state   <= S_FINISH;
                    end else begin
                        state <= S_EPOCH;
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    assign bus.smp_ready = (state == S_FETCH);
    assign bus.ld_smp    = (state == S_FETCH) && bus.smp_valid;
    assign bus.init_wb   = (state == S_INIT);
    assign bus.init_yin  = (state == S_CLR);
    assign bus.acc_en    = (state == S_ACC);
    assign bus.add_b     = (state == S_BIAS);
    assign bus.upd_w     = (state == S_UPD);
    assign bus.upd_b     = (state == S_UPDB);
    assign bus.idx       = cnt_en ? cnt : '0;
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_FINISH);

endmodule

// File: tb/tb_perceptron_train_ctrl_n.sv
// Scoreboard bench for perceptron_train_ctrl_n: planned error patterns per
// epoch/sample drive neq, and expected per-sample and per-run results are queued.
`timescale 1ns/1ps
module tb_perceptron_train_ctrl_n;
    import perceptron_pkg::*;

    localparam int N_IN      = 4;
    localparam int MAX_EPOCH = 3;
    localparam int EPOCH_W   = 8;

    typedef struct {
        int acc; int upd; int updb; int addb; int yin; int lat;
    } smp_exp_t;
    typedef struct {
        int conv; int tmo; int ep;
    } run_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, done, converged, timeout;
    logic [EPOCH_W-1:0] epoch;

    perceptron_train_ctrl_n_if #(.N_IN(N_IN)) bus ();

    perceptron_train_ctrl_n #(
        .N_IN      (N_IN),
        .MAX_EPOCH (MAX_EPOCH),
        .EPOCH_W   (EPOCH_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .converged (converged),
        .timeout   (timeout),
        .epoch     (epoch)
    );

    always #5 clk = ~clk;

    smp_exp_t sq[$];
    run_exp_t dq[$];
    bit plan [0:7][0:7];
    int n_smp = 4;
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit epoch_err(input int e);
        for (int s = 0; s < n_smp; s++) if (plan[e][s]) return 1'b1;
        return 1'b0;
    endfunction

    // Run outcome straight from the rules: first clean epoch converges,
    // otherwise the run stops after MAX_EPOCH epochs.
    function automatic run_exp_t predict();
        run_exp_t r;
        for (int e = 0; e < MAX_EPOCH; e++) begin
            if (!epoch_err(e)) begin
                r.conv = 1; r.tmo = 0; r.ep = e + 1;
                return r;
            end
        end
        r.conv = 0; r.tmo = 1; r.ep = MAX_EPOCH;
        return r;
    endfunction

    function automatic int out_vec();
        return int'({busy, done, converged, timeout, bus.smp_ready, bus.ld_smp,
                     bus.init_wb, bus.init_yin, bus.acc_en, bus.add_b,
                     bus.upd_w, bus.upd_b});
    endfunction

    task automatic clear_plan();
        for (int e = 0; e < 8; e++)
            for (int s = 0; s < 8; s++) plan[e][s] = 1'b0;
    endtask

    // Monitor: measures each sample's strobe activity between handshakes.
    initial begin : monitor
        bit in_smp = 0;
        bit prev_done = 0;
        int m_acc = 0, m_upd = 0, m_updb = 0, m_addb = 0, m_yin = 0, m_lat = 0;
        int m_idxerr = 0, init_cnt = 0;
        smp_exp_t se;
        run_exp_t re;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_smp = 0; prev_done = 0; init_cnt = 0;
            end else begin
                check("ld_smp_vs_handshake", int'(bus.ld_smp), int'(bus.smp_ready & bus.smp_valid));
                check("strobe_exclusive", int'($countones({bus.init_wb, bus.init_yin, bus.ld_smp,
                      bus.acc_en, bus.add_b, bus.upd_w, bus.upd_b}) > 1), 0);
                if (!(bus.acc_en || bus.upd_w)) check("idx_idle_zero", int'(bus.idx), 0);
                check("conv_and_timeout", int'(converged & timeout), 0);
                check("done_single", int'(prev_done & done), 0);
                prev_done = done;
                if (bus.init_wb) init_cnt++;
                if (in_smp) begin
                    m_lat++;
                    if (bus.acc_en) begin if (int'(bus.idx) != m_acc) m_idxerr++; m_acc++; end
                    if (bus.upd_w)  begin if (int'(bus.idx) != m_upd) m_idxerr++; m_upd++; end
                    if (bus.upd_b)    m_updb++;
                    if (bus.add_b)    m_addb++;
                    if (bus.init_yin) m_yin++;
                    if (bus.smp_ready || done) begin
                        in_smp = 0;
                        if (sq.size() == 0) begin
                            check("sample_unexpected", 1, 0);
                        end else begin
                            se = sq.pop_front();
                            check("acc_en_cycles", m_acc, se.acc);
                            check("upd_w_cycles", m_upd, se.upd);
                            check("upd_b_cycles", m_updb, se.updb);
                            check("add_b_cycles", m_addb, se.addb);
                            check("init_yin_cycles", m_yin, se.yin);
                            check("idx_sequence_errors", m_idxerr, 0);
                            check("sample_latency", m_lat, se.lat);
                        end
                    end
                end
                if (bus.ld_smp) begin
                    in_smp = 1;
                    m_acc = 0; m_upd = 0; m_updb = 0; m_addb = 0; m_yin = 0;
                    m_lat = 0; m_idxerr = 0;
                end
                if (done) begin
                    if (dq.size() == 0) begin
                        check("done_unexpected", 1, 0);
                    end else begin
                        re = dq.pop_front();
                        check("done_converged", int'(converged), re.conv);
                        check("done_timeout", int'(timeout), re.tmo);
                        check("done_epoch", int'(epoch), re.ep);
                    end
                    check("init_wb_pulses", init_cnt, 1);
                    init_cnt = 0;
                end
            end
        end
    end

    // Drives one training run: sample memory + datapath neq from the plan.
    task automatic run_training(input int dens, input bit gap, input bit abort_upd2);
        run_exp_t ex;
        int hs = 0, gap_left = 0, cyc = 0, e, s, base, lat;
        bit hs_now, fin = 0, er, lst, ends;
        ex = predict();
        if (!abort_upd2) dq.push_back(ex);
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        while (!fin && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            hs_now = bus.ld_smp;
            start = bus.acc_en ? 1'($urandom_range(0, 1)) : 1'b0;
            if (gap_left > 0 && (gap_left < 5 || bus.smp_ready)) begin
                check("gap_holds_fetch", int'(bus.smp_ready), 1);
                check("gap_no_ld_smp", int'(bus.ld_smp), 0);
                gap_left--;
            end
            if (done) begin
                fin = 1;
                start = 1'b0;
            end
            if (abort_upd2 && bus.upd_w && bus.idx == 2) begin
                rst = 1'b1;
                @(posedge clk); #1;
                check("rst_mid_outputs", out_vec(), 0);
                check("rst_mid_idx", int'(bus.idx), 0);
                check("rst_mid_epoch", int'(epoch), 0);
                @(negedge clk);
                sq.delete();
                dq.delete();
                #1 rst = 1'b0;
                return;
            end
            if (!fin) begin
                @(posedge clk); #1;
                if (hs_now) begin
                    e = (hs / n_smp > 7) ? 7 : hs / n_smp;
                    s = hs % n_smp;
                    er = plan[e][s];
                    lst = (s == n_smp - 1);
                    ends = lst && (!epoch_err(e) || e + 1 == MAX_EPOCH);
                    base = er ? 2 * N_IN + 5 : N_IN + 4;
                    lat = ends ? base + 1 : (lst ? base + 2 : base);
                    bus.neq = er;
                    sq.push_back('{N_IN, er ? N_IN : 0, int'(er), 1, 1, lat});
                    hs++;
                    if (gap && hs == 2) gap_left = 5;
                end
                bus.smp_valid = (gap_left > 0) ? 1'b0 : ($urandom_range(1, 100) <= dens);
                bus.smp_last = bus.smp_valid ? ((hs % n_smp) == n_smp - 1)
                                             : 1'($urandom_range(0, 1));
            end
        end
        bus.smp_valid = 1'b0;
        if (!fin) begin
            check("run_completed", 0, 1);
            rst = 1'b1;
            @(negedge clk);
            sq.delete();
            dq.delete();
            #1 rst = 1'b0;
            return;
        end
        check("handshake_count", hs, ex.ep * n_smp);
        repeat (3) @(negedge clk);
        check("idle_busy", int'(busy), 0);
        check("sticky_converged", int'(converged), ex.conv);
        check("sticky_timeout", int'(timeout), ex.tmo);
        check("sticky_epoch", int'(epoch), ex.ep);
        check("samples_outstanding", sq.size(), 0);
    endtask

    initial begin : stimulus
        int p;
        bus.smp_valid = 1'b0;
        bus.smp_last  = 1'b0;
        bus.neq       = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", out_vec(), 0);
        check("reset_epoch", int'(epoch), 0);
        check("reset_idx", int'(bus.idx), 0);
        rst = 1'b0;

        // Clean single epoch.
        n_smp = 4; clear_plan();
        run_training(100, 1'b0, 1'b0);
        // Error on the second sample of epoch 1, with a 5-cycle valid gap.
        clear_plan(); plan[0][1] = 1'b1;
        run_training(100, 1'b1, 1'b0);
        // Errors everywhere: timeout at MAX_EPOCH.
        for (int e = 0; e < 8; e++) for (int s = 0; s < 8; s++) plan[e][s] = 1'b1;
        run_training(100, 1'b0, 1'b0);
        // Reset in the middle of a weight update, then a normal run.
        clear_plan(); plan[0][0] = 1'b1;
        run_training(100, 1'b0, 1'b1);
        clear_plan();
        run_training(100, 1'b0, 1'b0);
        // Randomized epoch lengths, error densities and valid gaps.
        for (int r = 0; r < 14; r++) begin
            n_smp = $urandom_range(1, 5);
            case ($urandom_range(0, 3))
                0: p = 0;
                1: p = 15;
                2: p = 40;
                default: p = 90;
            endcase
            for (int e = 0; e < 8; e++)
                for (int s = 0; s < 8; s++) plan[e][s] = ($urandom_range(0, 99) < p);
            run_training($urandom_range(30, 100), 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/perceptron_train_ctrl_n.md
PERCEPTRON_TRAIN_CTRL_N -- requirements
Module: perceptron_train_ctrl_n

Interface
REQ-001 SHALL have parameter N_IN, default 4, number of weighted inputs (2..16).
REQ-002 SHALL have parameter MAX_EPOCH, default 255, epoch limit before timeout (1..2^EPOCH_W-1).
REQ-003 SHALL have parameter EPOCH_W, default 8, width of the epoch counter.
REQ-004 SHALL derive localparam IDX_W = max(1, clog2(N_IN)).
REQ-005 clk  in  1  clock, rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  begin a training run; sampled in IDLE only.
REQ-008 smp_valid  in  1  sample memory presents a sample (x[0..N_IN-1], target).
REQ-009 smp_last  in  1  presented sample is the last of the epoch; qualified by smp_valid.
REQ-010 smp_ready  out  1  sample accepted this cycle (smp_valid & smp_ready).
REQ-011 neq  in  1  datapath: activation(yin) != target; valid in CHECK.
REQ-012 init_wb  out  1  clear all weights and bias.
REQ-013 init_yin  out  1  clear accumulator yin.
REQ-014 ld_smp  out  1  latch accepted sample into datapath registers.
REQ-015 acc_en  out  1  yin += x[idx]*w[idx].
REQ-016 add_b  out  1  yin += b.
REQ-017 upd_w  out  1  w[idx] += alpha*t*x[idx].
REQ-018 upd_b  out  1  b += alpha*t.
REQ-019 idx  out  IDX_W  input index for acc_en/upd_w; 0 otherwise.
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 done  out  1  one-cycle pulse on run completion.
REQ-022 converged  out  1  last run ended on an error-free epoch; sticky.
REQ-023 timeout  out  1  last run ended on MAX_EPOCH; sticky.
REQ-024 epoch  out  EPOCH_W  completed-epoch count of current/last run.

Function
REQ-025 States: IDLE, INIT, EPOCH, FETCH, CLR, ACC, BIAS, CHECK, UPD, UPDB, ENDEP, FINISH.
REQ-026 IDLE: start=1 -> INIT, clearing converged, timeout, epoch; else stay.
REQ-027 INIT: init_wb=1 one cycle -> EPOCH.
REQ-028 EPOCH: clear internal epoch-error flag and last flag -> FETCH.
REQ-029 FETCH: smp_ready=1, ld_smp=1 only when smp_valid=1; capture smp_last; advance to CLR on handshake, else wait (no timeout).
REQ-030 CLR: init_yin=1, idx reset to 0 -> ACC.
REQ-031 ACC: acc_en=1 for exactly N_IN cycles, idx 0..N_IN-1 -> BIAS.
REQ-032 BIAS: add_b=1 one cycle -> CHECK.
REQ-033 CHECK: neq=1 -> set error flag, UPD (idx=0); neq=0 & !last -> FETCH; neq=0 & last -> ENDEP.
REQ-034 UPD: upd_w=1 for exactly N_IN cycles, idx 0..N_IN-1 -> UPDB.
REQ-035 UPDB: upd_b=1 one cycle; last -> ENDEP, else FETCH.
REQ-036 ENDEP: epoch += 1; error flag=0 -> FINISH with converged=1; else epoch+1==MAX_EPOCH -> FINISH with timeout=1; else EPOCH.
REQ-037 FINISH: done=1 one cycle -> IDLE; converged/timeout/epoch held until next accepted start.
REQ-038 converged and timeout SHALL never both be 1.
REQ-039 All control outputs SHALL be Moore-decoded from state and idx, except smp_ready/ld_smp which also depend on smp_valid in FETCH.
REQ-040 Per-sample latency with no error: 1+1+N_IN+1+1 = N_IN+4 cycles from FETCH handshake to next FETCH; with error: +N_IN+1.
REQ-041 start while busy SHALL be ignored; smp_valid outside FETCH SHALL be ignored.
REQ-042 epoch SHALL not wrap; MAX_EPOCH caps it.

Reset
REQ-043 rst=1 SHALL force IDLE, idx=0, epoch=0, error/last flags=0, converged=0, timeout=0, all outputs 0, at any time including mid-run; no done pulse.

Structure
REQ-044 State enum, default N_IN/MAX_EPOCH/EPOCH_W SHALL live in shared package perceptron_pkg.
REQ-045 One sub-module, idx_counter (clear, enable, terminal-count at N_IN-1), SHALL drive idx for ACC and UPD.

Verification
REQ-046 N_IN=4, 4-sample epoch, neq=0 always -> done after 1 epoch, converged=1, epoch=1, acc_en high 4 cycles per sample.
REQ-047 neq=1 on sample 2 of epoch 1, 0 thereafter -> upd_w idx 0..3 then upd_b once; epoch 2 clean -> converged=1, epoch=2.
REQ-048 MAX_EPOCH=3, neq=1 always -> timeout=1, converged=0, epoch=3, done single pulse.
REQ-049 smp_valid low 5 cycles in FETCH -> FSM holds, smp_ready high, no ld_smp until valid.
REQ-050 rst asserted during UPD idx=2 -> next cycle all outputs 0, busy=0; start then runs normally from INIT.
REQ-051 start pulsed during ACC and smp_valid outside FETCH -> no state or output change.
